// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage hazard control bundle: decoder-side selects and strobes in,
// stall/issue/bubble/dump status back out.
interface decode_hazard_ctrl_if;
    logic        id_valid;
    logic        id_flush;
    logic [2:0]  rs_sel;
    logic        rs_used;
    logic [2:0]  rt_sel;
    logic        rt_used;
    logic [2:0]  wr_sel;
    logic        wr_en;
    logic        id_halt;
    logic        stall;
    logic        issue;
    logic        bubble;
    logic        create_dump;
    logic        halted;
    logic [15:0] stall_cycles;

    // Decoder side: presents the instruction, observes the control response
    modport master (
        output id_valid, id_flush, rs_sel, rs_used, rt_sel, rt_used,
               wr_sel, wr_en, id_halt,
        input  stall, issue, bubble, create_dump, halted, stall_cycles
    );

    // Controller side
    modport slave (
        input  id_valid, id_flush, rs_sel, rs_used, rt_sel, rt_used,
               wr_sel, wr_en, id_halt,
        output stall, issue, bubble, create_dump, halted, stall_cycles
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Scoreboard issue controller for the decode stage. One 2-bit countdown per
// architectural register marks a write still in flight; decode stalls while
// a source it reads is busy. HALT is held in ID until every counter drains,
// then a single dump pulse is raised and the core parks in DONE.
module decode_hazard_ctrl #(
    parameter int WB_LAT    = 3,
    parameter int RF_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] LOAD_VAL   = 2'(WB_LAT);
    localparam logic [1:0] BYPASS_LIM = 2'(RF_BYPASS);

    state_t      state_r;
    logic [1:0]  cnt_r [8];
    logic [15:0] stall_cycles_r;

    logic [7:0]  nz_s;
    logic        haz_s;
    logic        all_zero_s;
    logic        stall_s;
    logic        issue_s;
    logic        bubble_s;
    logic        dump_s;
    logic        halted_s;
    logic        halt_go_s;
    logic        load_s;

    // A counter at or below the bypass limit is written before it is read
    function automatic logic busy_f(input logic [1:0] c);
        return (c > BYPASS_LIM);
    endfunction

    // Hazard and drain-complete detection, always on the current counters
    always_comb begin
        nz_s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            nz_s[i] = |cnt_r[i];
        end
        all_zero_s = ~|nz_s;
        haz_s      = (bus.rs_used & busy_f(cnt_r[bus.rs_sel]))
                   | (bus.rt_used & busy_f(cnt_r[bus.rt_sel]));
        halt_go_s  = bus.id_valid & bus.id_halt & ~bus.id_flush;
    end

    // Per-state stall/issue/bubble/dump decode
    always_comb begin
        stall_s  = 1'b0;
        issue_s  = 1'b0;
        bubble_s = 1'b1;
        dump_s   = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                stall_s  = bus.id_valid & ~bus.id_flush & (haz_s | bus.id_halt);
                issue_s  = bus.id_valid & ~bus.id_flush & ~stall_s;
                bubble_s = ~issue_s;
            end
            ST_DRAIN: begin
                // A flushed HALT was on a wrong path: release the front end now
                stall_s = ~bus.id_flush;
                dump_s  = ~bus.id_flush & all_zero_s;
            end
            ST_DONE: begin
                stall_s  = 1'b1;
                halted_s = 1'b1;
            end
            default: begin
                stall_s  = 1'b0;
                issue_s  = 1'b0;
                bubble_s = 1'b1;
            end
        endcase
        load_s = issue_s & bus.wr_en;
    end

    // HALT sequencing: RUN -> DRAIN -> DONE, flush aborts the drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_go_s) state_r <= ST_DRAIN;
                    else           state_r <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (bus.id_flush)    state_r <= ST_RUN;
                    else if (all_zero_s) state_r <= ST_DONE;
                    else                 state_r <= ST_DRAIN;
                end
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_RUN;
            endcase
        end
    end

    // Scoreboard: youngest issuing writer reloads, everything else counts down
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                cnt_r[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load_s && (bus.wr_sel == 3'(i))) begin
                    cnt_r[i] <= LOAD_VAL;
                end else if (cnt_r[i] != 2'd0) begin
                    cnt_r[i] <= cnt_r[i] - 2'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_r <= 16'd0;
        end else if (stall_s && (stall_cycles_r != 16'hFFFF)) begin
            stall_cycles_r <= stall_cycles_r + 16'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the inputs
    assign bus.stall        = rst & stall_s;
    assign bus.issue        = rst & issue_s;
    assign bus.bubble       = rst & bubble_s;
    assign bus.create_dump  = rst & dump_s;
    assign bus.halted       = rst & halted_s;
    assign bus.stall_cycles = stall_cycles_r;
endmodule
